// File: rtl/systolic_feeder.sv
// Edge feeder for the NxN seq_pe array: weight preload, skewed activation streaming, zero drain.
// Optional stall counter built only when FEEDER_BUBBLE_CNT_EN is defined.
module systolic_feeder #(
    parameter int N     = 4,
    parameter int WBITS = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [N*WBITS-1:0] w_row,
    input  logic               w_valid,
    output logic               w_ready,
    input  logic [N*WBITS-1:0] act_vec,
    input  logic               act_valid,
    input  logic               act_last,
    output logic               act_ready,
    output logic               pe_load,
    output logic [N*WBITS-1:0] pe_stat_out,
    output logic [N*WBITS-1:0] pe_pass_out,
    output logic [N-1:0]       lane_tag,
    output logic               busy,
    output logic               done,
    output logic [15:0]        bubble_cnt
);

    localparam int CW = $clog2(2 * N) + 1;
    localparam logic [CW-1:0] ROW_LAST   = CW'(N - 1);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(2 * N - 2);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD_W = 2'd1;
    localparam logic [1:0] S_STREAM = 2'd2;
    localparam logic [1:0] S_DRAIN  = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [CW-1:0]      r_row_cnt;
    logic [CW-1:0]      r_drain_cnt;
    logic               w_start_acc;
    logic               w_w_acc;
    logic               w_a_acc;
    logic [N*WBITS-1:0] w_inj_data;

    assign w_start_acc = (r_state == S_IDLE) && start;
    assign w_w_acc     = (r_state == S_LOAD_W) && w_valid;
    assign w_a_acc     = (r_state == S_STREAM) && act_valid;

    // Anything not accepted in STREAM enters the skew pipeline as a zero bubble
    assign w_inj_data  = w_a_acc ? act_vec : '0;

    // Next-state decode for the job sequence
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_LOAD_W;
                else       w_state_nxt = S_IDLE;
            end
            S_LOAD_W: begin
                if (w_w_acc && (r_row_cnt == ROW_LAST)) w_state_nxt = S_STREAM;
                else                                    w_state_nxt = S_LOAD_W;
            end
            S_STREAM: begin
                if (w_a_acc && act_last) w_state_nxt = S_DRAIN;
                else                     w_state_nxt = S_STREAM;
            end
            S_DRAIN: begin
                if (r_drain_cnt == DRAIN_LAST) w_state_nxt = S_IDLE;
                else                           w_state_nxt = S_DRAIN;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register plus row and drain counters
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_row_cnt   <= '0;
            r_drain_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start_acc)  r_row_cnt <= '0;
            else if (w_w_acc) r_row_cnt <= r_row_cnt + CW'(1);
            else              r_row_cnt <= r_row_cnt;
            if (w_a_acc && act_last)      r_drain_cnt <= '0;
            else if (r_state == S_DRAIN)  r_drain_cnt <= r_drain_cnt + CW'(1);
            else                          r_drain_cnt <= r_drain_cnt;
        end
    end

    // Lane i gets i+1 stages so the array sees a diagonal wavefront
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
        logic [WBITS-1:0] r_d [0:gi];
        logic             r_t [0:gi];

        // Per-lane skew shift register for data and tag
        always_ff @(posedge clk) begin
            if (reset) begin
                for (int k = 0; k <= gi; k++) begin
                    r_d[k] <= '0;
                    r_t[k] <= 1'b0;
                end
            end else begin
                r_d[0] <= w_inj_data[gi*WBITS +: WBITS];
                r_t[0] <= w_a_acc;
                for (int k = 1; k <= gi; k++) begin
                    r_d[k] <= r_d[k-1];
                    r_t[k] <= r_t[k-1];
                end
            end
        end

        assign pe_pass_out[gi*WBITS +: WBITS] = r_d[gi];
        assign lane_tag[gi]                   = r_t[gi];
    end

`ifdef FEEDER_BUBBLE_CNT_EN
    logic [15:0] r_bubble_cnt;

    // Saturating count of empty STREAM slots; holds through DRAIN/IDLE until next start
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bubble_cnt <= 16'h0000;
        end else if (w_start_acc) begin
            r_bubble_cnt <= 16'h0000;
        end else if ((r_state == S_STREAM) && !act_valid && (r_bubble_cnt != 16'hFFFF)) begin
            r_bubble_cnt <= r_bubble_cnt + 16'h0001;
        end else begin
            r_bubble_cnt <= r_bubble_cnt;
        end
    end

    assign bubble_cnt = r_bubble_cnt;
`else
    assign bubble_cnt = 16'h0000;
`endif

    // Weight load is a same-cycle pass-through so the PE chain shifts on the handshake
    assign w_ready     = (r_state == S_LOAD_W);
    assign act_ready   = (r_state == S_STREAM);
    assign pe_load     = w_w_acc;
    assign pe_stat_out = w_w_acc ? w_row : '0;
    assign busy        = (r_state != S_IDLE);
    assign done        = (r_state == S_DRAIN) && (r_drain_cnt == DRAIN_LAST);

endmodule

// File: tb/tb_systolic_feeder.sv
// Bench for systolic_feeder: directed table, hand sequences and random jobs vs a history model.
module tb_systolic_feeder;
    localparam int N = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] w_row;
    logic        w_valid;
    logic        w_ready;
    logic [31:0] act_vec;
    logic        act_valid;
    logic        act_last;
    logic        act_ready;
    logic        pe_load;
    logic [31:0] pe_stat_out;
    logic [31:0] pe_pass_out;
    logic [3:0]  lane_tag;
    logic        busy;
    logic        done;
    logic [15:0] bubble_cnt;

    int n_checks = 0;
    int n_errors = 0;

    systolic_feeder #(.N(4), .WBITS(8)) dut (
        .clk(clk), .reset(reset), .start(start),
        .w_row(w_row), .w_valid(w_valid), .w_ready(w_ready),
        .act_vec(act_vec), .act_valid(act_valid), .act_last(act_last), .act_ready(act_ready),
        .pe_load(pe_load), .pe_stat_out(pe_stat_out), .pe_pass_out(pe_pass_out),
        .lane_tag(lane_tag), .busy(busy), .done(done), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: job phase plus a history of what was injected at each edge
    typedef struct packed { logic [31:0] d; logic t; } inj_t;
    inj_t hist[$];
    int   m_phase;   // 0 idle, 1 load, 2 stream, 3 drain
    int   m_rows;
    int   m_drain;
    int   m_bub;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_check();
        logic [31:0] ep;
        logic [3:0]  et;
        int          sz;
        int          eb;
        ep = 32'h0;
        et = 4'h0;
        sz = hist.size();
        for (int i = 0; i < N; i++) begin
            if (sz > i) begin
                ep[i*8 +: 8] = hist[sz-1-i].d[i*8 +: 8];
                et[i]        = hist[sz-1-i].t;
            end
        end
`ifdef FEEDER_BUBBLE_CNT_EN
        eb = m_bub;
`else
        eb = 0;
`endif
        chk("busy",      {31'h0, busy},      {31'h0, m_phase != 0});
        chk("w_ready",   {31'h0, w_ready},   {31'h0, m_phase == 1});
        chk("act_ready", {31'h0, act_ready}, {31'h0, m_phase == 2});
        chk("pe_load",   {31'h0, pe_load},   {31'h0, (m_phase == 1) && w_valid});
        chk("pe_stat",   pe_stat_out,        ((m_phase == 1) && w_valid) ? w_row : 32'h0);
        chk("pe_pass",   pe_pass_out,        ep);
        chk("lane_tag",  {28'h0, lane_tag},  {28'h0, et});
        chk("done",      {31'h0, done},      {31'h0, (m_phase == 3) && (m_drain == 2*N-2)});
        chk("bubble",    {16'h0, bubble_cnt}, eb);
    endtask

    task automatic model_update();
        logic acc;
        if (reset) begin
            m_phase = 0; m_rows = 0; m_drain = 0; m_bub = 0;
            hist.delete();
        end else begin
            acc = (m_phase == 2) && act_valid;
            hist.push_back('{acc ? act_vec : 32'h0, acc});
            if (hist.size() > N) void'(hist.pop_front());
            case (m_phase)
                0: if (start) begin m_phase = 1; m_rows = 0; m_bub = 0; end
                1: if (w_valid) begin
                       m_rows++;
                       if (m_rows == N) m_phase = 2;
                   end
                2: begin
                       if (!act_valid && m_bub != 65535) m_bub++;
                       if (acc && act_last) begin m_phase = 3; m_drain = 0; end
                   end
                3: if (m_drain == 2*N-2) m_phase = 0; else m_drain++;
                default: m_phase = 0;
            endcase
        end
    endtask

    task automatic cycle();
        #1;
        model_check();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic set_in(input logic s, input logic wv, input logic [31:0] wr,
                          input logic av, input logic [31:0] avec, input logic al);
        start = s; w_valid = wv; w_row = wr; act_valid = av; act_vec = avec; act_last = al;
    endtask

    task automatic load_rows();
        set_in(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0); cycle();
        for (int r = 0; r < N; r++) begin
            set_in(1'b0, 1'b1, $urandom, 1'b0, 32'h0, 1'b0); cycle();
        end
    endtask

    typedef struct {
        logic s; logic wv; logic [31:0] wr; logic av; logic [31:0] avec; logic al;
        logic e_busy; logic e_load; logic [31:0] e_stat; logic [31:0] e_pass;
        logic [3:0] e_tag; logic e_done;
    } vec_t;
    vec_t tbl[15];

    initial begin
        reset = 1'b1;
        set_in(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        m_phase = 0; m_rows = 0; m_drain = 0; m_bub = 0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Directed job: load rows 4..1, one vector {4,3,2,1} with last, drain; start at row 8 ignored
        tbl[0]  = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        4'h0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 32'h04040404, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h04040404, 32'h0,        4'h0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 32'h03030303, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h03030303, 32'h0,        4'h0, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 32'h02020202, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h02020202, 32'h0,        4'h0, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 32'h01010101, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h01010101, 32'h0,        4'h0, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h04030201, 1'b1, 1'b1, 1'b0, 32'h0,        32'h0,        4'h0, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0,        32'h00000001, 4'h1, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0,        32'h00000200, 4'h2, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0,        32'h00030000, 4'h4, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0,        32'h04000000, 4'h8, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0,        32'h0,        4'h0, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0,        32'h0,        4'h0, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0,        32'h0,        4'h0, 1'b1};
        tbl[13] = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        4'h0, 1'b0};
        tbl[14] = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        4'h0, 1'b0};
        for (int i = 0; i < 15; i++) begin
            set_in(tbl[i].s, tbl[i].wv, tbl[i].wr, tbl[i].av, tbl[i].avec, tbl[i].al);
            #1;
            chk($sformatf("tbl%0d_busy", i), {31'h0, busy},    {31'h0, tbl[i].e_busy});
            chk($sformatf("tbl%0d_load", i), {31'h0, pe_load}, {31'h0, tbl[i].e_load});
            chk($sformatf("tbl%0d_stat", i), pe_stat_out,      tbl[i].e_stat);
            chk($sformatf("tbl%0d_pass", i), pe_pass_out,      tbl[i].e_pass);
            chk($sformatf("tbl%0d_tag", i),  {28'h0, lane_tag}, {28'h0, tbl[i].e_tag});
            chk($sformatf("tbl%0d_done", i), {31'h0, done},    {31'h0, tbl[i].e_done});
            cycle();
        end

        // Reset for 3 cycles in the middle of STREAM, then a clean bubble job (valid 1,0,1)
        load_rows();
        set_in(1'b0, 1'b0, 32'h0, 1'b1, 32'hA1B2C3D4, 1'b0); cycle();
        set_in(1'b0, 1'b0, 32'h0, 1'b1, 32'h55667788, 1'b0); cycle();
        reset = 1'b1;
        for (int r = 0; r < 3; r++) begin
            cycle();
            chk("rst_busy", {31'h0, busy}, 32'h0);
            chk("rst_pass", pe_pass_out, 32'h0);
            chk("rst_tag",  {28'h0, lane_tag}, 32'h0);
            chk("rst_done", {31'h0, done}, 32'h0);
        end
        reset = 1'b0;
        load_rows();
        set_in(1'b0, 1'b0, 32'h0, 1'b1, 32'h11223344, 1'b0); cycle();
        set_in(1'b0, 1'b0, 32'h0, 1'b0, 32'hDEADBEEF, 1'b1); cycle();
        set_in(1'b0, 1'b0, 32'h0, 1'b1, 32'h99AABBCC, 1'b1); cycle();
        set_in(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        for (int k = 0; k < 2*N; k++) cycle();
`ifdef FEEDER_BUBBLE_CNT_EN
        chk("bubble_after_job", {16'h0, bubble_cnt}, 32'd1);
`else
        chk("bubble_after_job", {16'h0, bubble_cnt}, 32'd0);
`endif
        chk("idle_after_bubble_job", {31'h0, busy}, 32'h0);

        // Random jobs with noise on every input
        for (int j = 0; j < 8; j++) begin
            int k;
            set_in(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0); cycle();
            k = 0;
            while (m_phase != 0 && k < 300) begin
                set_in($urandom_range(0, 7) == 0, $urandom_range(0, 9) < 7, $urandom,
                       $urandom_range(0, 9) < 6, $urandom,
                       ($urandom_range(0, 7) == 0) || (k > 40));
                cycle();
                k++;
            end
            if (m_phase != 0) chk("job_timeout", 32'd1, 32'd0);
            set_in(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
            repeat ($urandom_range(0, 3)) cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
